fetch_controller: RTL and testbench

- Sequences instruction fetch for the single-issue core: owns the fetch PC, issues one-at-a-time requests to instruction memory over a req/gnt + rvalid handshake, and buffers returned instructions for decode.
- Sits between the instruction memory and the decode stage.
- Applies jump/branch redirects, squashes in-flight fetches on a redirect, and throttles fetch on downstream back-pressure.

---
 rtl/fetch_controller_pkg.sv | 15 +
 rtl/fetch_buffer.sv | 81 ++++++++
 rtl/fetch_controller.sv | 117 +++++++++++
 tb/tb_fetch_controller.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_controller_pkg.sv
// Shared definitions for the instruction fetch controller: FSM state
// encoding, PC increment and the default reset PC.
package fetch_controller_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_REQ   = 2'd1,
      ST_WAIT  = 2'd2,
      ST_FLUSH = 2'd3
   } fetch_state_e;

   localparam int unsigned PC_INC           = 4;
   localparam int unsigned DEFAULT_RESET_PC = 0;

endpackage

// File: rtl/fetch_buffer.sv
// Small FIFO of {pc, instr} pairs between the fetch FSM and decode.
// Flush empties it in one cycle and overrides any push/pop in that cycle.
module fetch_buffer
   import fetch_controller_pkg::*;
#(
   parameter int unsigned PC_WIDTH    = 30,
   parameter int unsigned INSTR_WIDTH = 32,
   parameter int unsigned BUF_DEPTH   = 2,
   localparam int unsigned AW         = $clog2(BUF_DEPTH),
   localparam int unsigned CW         = AW + 1
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   push_i,
   input  logic [PC_WIDTH-1:0]    push_pc_i,
   input  logic [INSTR_WIDTH-1:0] push_data_i,
   input  logic                   pop_i,
   input  logic                   flush_i,
   output logic [CW-1:0]          count_o,
   output logic [PC_WIDTH-1:0]    head_pc_o,
   output logic [INSTR_WIDTH-1:0] head_data_o
);

   localparam logic [CW-1:0] DEPTH_V = CW'(BUF_DEPTH);

   logic [PC_WIDTH-1:0]    pc_mem_q   [BUF_DEPTH];
   logic [INSTR_WIDTH-1:0] data_mem_q [BUF_DEPTH];
   logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]          count_q, count_d;
   logic                   do_push, do_pop;

   assign do_push = push_i & ~flush_i;
   assign do_pop  = pop_i & (count_q != '0) & ~flush_i;

   // Pointer and occupancy next-state; pointers wrap since depth is a power of 2
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
         if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
         count_d = count_q + CW'(do_push) - CW'(do_pop);
      end
   end

   // State registers and storage; storage is cleared so head reads 0 after reset
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < BUF_DEPTH; i++) begin
            pc_mem_q[i]   <= '0;
            data_mem_q[i] <= '0;
         end
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         if (do_push) begin
            pc_mem_q[wr_ptr_q]   <= push_pc_i;
            data_mem_q[wr_ptr_q] <= push_data_i;
         end
      end
   end

   assign count_o     = count_q;
   assign head_pc_o   = pc_mem_q[rd_ptr_q];
   assign head_data_o = data_mem_q[rd_ptr_q];

   // The fetch FSM only requests when there is room, so a full push is a bug
   a_no_push_when_full: assert property (@(posedge clk) disable iff (!reset)
      !(push_i && !flush_i && count_q == DEPTH_V));

endmodule

// File: rtl/fetch_controller.sv
// Instruction fetch sequencer: owns the fetch PC, issues one request at a
// time to instruction memory, applies redirects and buffers responses.
module fetch_controller
   import fetch_controller_pkg::*;
#(
   parameter int unsigned PC_WIDTH    = 30,
   parameter int unsigned INSTR_WIDTH = 32,
   parameter int unsigned RESET_PC    = DEFAULT_RESET_PC,
   parameter int unsigned BUF_DEPTH   = 2
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   redirect_en,
   input  logic [PC_WIDTH-1:0]    redirect_addr,
   output logic                   imem_req,
   output logic [PC_WIDTH-1:0]    imem_addr,
   input  logic                   imem_gnt,
   input  logic                   imem_rvalid,
   input  logic [INSTR_WIDTH-1:0] imem_rdata,
   output logic                   inst_valid,
   input  logic                   inst_ready,
   output logic [INSTR_WIDTH-1:0] inst_data,
   output logic [PC_WIDTH-1:0]    inst_pc,
   output logic                   fetch_busy
);

   localparam int unsigned CW         = $clog2(BUF_DEPTH) + 1;
   localparam logic [CW-1:0] DEPTH_V  = CW'(BUF_DEPTH);
   localparam logic [PC_WIDTH-1:0] RESET_PC_V = PC_WIDTH'(RESET_PC);

   fetch_state_e          state_q, state_d;
   logic [PC_WIDTH-1:0]   fetch_pc_q, fetch_pc_d;
   logic [PC_WIDTH-1:0]   pend_pc_q, pend_pc_d;
   logic [CW-1:0]         count;
   logic [CW-1:0]         count_after_push;
   logic                  push, pop;

   assign pop              = inst_valid & inst_ready;
   // Occupancy the buffer will have after this cycle's push and pop
   assign count_after_push = count + CW'(1) - CW'(pop);

   // Next-state, PC update and buffer push decisions
   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      pend_pc_d  = pend_pc_q;
      push       = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (redirect_en)         fetch_pc_d = redirect_addr;
            else if (count < DEPTH_V) state_d   = ST_REQ;
         end
         ST_REQ: begin
            // A grant coincident with a redirect is abandoned
            if (redirect_en) begin
               fetch_pc_d = redirect_addr;
               state_d    = ST_IDLE;
            end else if (imem_gnt) begin
               pend_pc_d  = fetch_pc_q;
               fetch_pc_d = fetch_pc_q + PC_WIDTH'(PC_INC);
               state_d    = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (redirect_en) begin
               fetch_pc_d = redirect_addr;
               state_d    = imem_rvalid ? ST_IDLE : ST_FLUSH;
            end else if (imem_rvalid) begin
               push    = 1'b1;
               state_d = (count_after_push < DEPTH_V) ? ST_REQ : ST_IDLE;
            end
         end
         ST_FLUSH: begin
            // Still owed one response from a wrong-path request; drop it
            if (redirect_en) fetch_pc_d = redirect_addr;
            if (imem_rvalid) state_d    = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // FSM and PC registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= ST_IDLE;
         fetch_pc_q <= RESET_PC_V;
         pend_pc_q  <= '0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         pend_pc_q  <= pend_pc_d;
      end
   end

   assign imem_req   = (state_q == ST_REQ);
   assign imem_addr  = fetch_pc_q;
   assign fetch_busy = (state_q == ST_WAIT) || (state_q == ST_FLUSH);
   assign inst_valid = (count != '0);

   fetch_buffer #(
      .PC_WIDTH    (PC_WIDTH),
      .INSTR_WIDTH (INSTR_WIDTH),
      .BUF_DEPTH   (BUF_DEPTH)
   ) u_buffer (
      .clk         (clk),
      .reset       (reset),
      .push_i      (push),
      .push_pc_i   (pend_pc_q),
      .push_data_i (imem_rdata),
      .pop_i       (pop),
      .flush_i     (redirect_en),
      .count_o     (count),
      .head_pc_o   (inst_pc),
      .head_data_o (inst_data)
   );

endmodule

// File: tb/tb_fetch_controller.sv
// Directed testbench for fetch_controller.
module tb_fetch_controller;

   logic        clk = 1'b0;
   logic        reset;
   logic        redirect_en;
   logic [29:0] redirect_addr;
   logic        imem_req;
   logic [29:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst_data;
   logic [29:0] inst_pc;
   logic        fetch_busy;

   int tests_run    = 0;
   int tests_failed = 0;

   // automatic memory model state
   logic        owe;
   logic [31:0] owe_data;
   int          cyc;
   logic [31:0] g_q[$];
   logic [31:0] pop_pc[$];
   logic [31:0] pop_data[$];
   int          rv_cyc[$];
   int          pop_cyc[$];

   fetch_controller dut (
      .clk           (clk),
      .reset         (reset),
      .redirect_en   (redirect_en),
      .redirect_addr (redirect_addr),
      .imem_req      (imem_req),
      .imem_addr     (imem_addr),
      .imem_gnt      (imem_gnt),
      .imem_rvalid   (imem_rvalid),
      .imem_rdata    (imem_rdata),
      .inst_valid    (inst_valid),
      .inst_ready    (inst_ready),
      .inst_data     (inst_data),
      .inst_pc       (inst_pc),
      .fetch_busy    (fetch_busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end else begin
         $display("[TB] ok   %s = 0x%0h", tag, act);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] q_at(input logic [31:0] q[$], input int i);
      if (i < q.size()) return q[i];
      return 32'hDEAD_BEEF;
   endfunction

   task automatic do_reset();
      reset         = 1'b0;
      redirect_en   = 1'b0;
      redirect_addr = '0;
      imem_gnt      = 1'b0;
      imem_rvalid   = 1'b0;
      imem_rdata    = '0;
      inst_ready    = 1'b0;
      owe           = 1'b0;
      owe_data      = '0;
      cyc           = 0;
      g_q.delete(); pop_pc.delete(); pop_data.delete();
      rv_cyc.delete(); pop_cyc.delete();
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
   endtask

   // One cycle of a memory that grants immediately and answers the next cycle
   task automatic mem_cycle();
      imem_rvalid = owe;
      imem_rdata  = owe_data;
      owe         = 1'b0;
      imem_gnt    = imem_req;
      if (imem_rvalid) rv_cyc.push_back(cyc);
      if (imem_req && imem_gnt) begin
         g_q.push_back(32'(imem_addr));
         owe      = 1'b1;
         owe_data = 32'hAAAA_0001 + 32'(imem_addr);
      end
      if (inst_valid && inst_ready) begin
         pop_pc.push_back(32'(inst_pc));
         pop_data.push_back(inst_data);
         pop_cyc.push_back(cyc);
      end
      cyc++;
      tick();
   endtask

   initial begin
      // ---- reset values
      do_reset();
      reset = 1'b0;
      #2;
      check("rst_imem_req",   32'(imem_req),   32'd0);
      check("rst_imem_addr",  32'(imem_addr),  32'd0);
      check("rst_inst_valid", 32'(inst_valid), 32'd0);
      check("rst_inst_data",  inst_data,       32'd0);
      check("rst_inst_pc",    32'(inst_pc),    32'd0);
      check("rst_fetch_busy", 32'(fetch_busy), 32'd0);

      // ---- streaming fetch with ready=1
      do_reset();
      inst_ready = 1'b1;
      repeat (9) mem_cycle();
      check("stream_addr0", q_at(g_q, 0), 32'h0);
      check("stream_addr1", q_at(g_q, 1), 32'h4);
      check("stream_addr2", q_at(g_q, 2), 32'h8);
      check("stream_pc0",   q_at(pop_pc, 0),   32'h0);
      check("stream_data0", q_at(pop_data, 0), 32'hAAAA_0001);
      check("stream_pc1",   q_at(pop_pc, 1),   32'h4);
      check("stream_data1", q_at(pop_data, 1), 32'hAAAA_0005);
      check("rvalid_to_valid_lat",
            32'((pop_cyc.size() > 0 && rv_cyc.size() > 0) ? pop_cyc[0] - rv_cyc[0] : -1), 32'd1);

      // ---- back-pressure: buffer fills to 2 and fetch stops
      do_reset();
      inst_ready = 1'b0;
      repeat (10) mem_cycle();
      check("bp_grants",     32'(g_q.size()),    32'd2);
      check("bp_no_pops",    32'(pop_pc.size()), 32'd0);
      check("bp_req_low",    32'(imem_req),      32'd0);
      check("bp_head_pc",    32'(inst_pc),       32'h0);
      inst_ready = 1'b1;
      repeat (4) mem_cycle();
      check("bp_drain_pc0",  q_at(pop_pc, 0), 32'h0);
      check("bp_drain_pc1",  q_at(pop_pc, 1), 32'h4);
      check("bp_resume_addr", q_at(g_q, 2),   32'h8);

      // ---- redirect while in WAIT, stale response two cycles later
      do_reset();
      inst_ready = 1'b1;
      tick();                                   // IDLE -> REQ
      check("wr_req_addr0", 32'(imem_addr), 32'h0);
      imem_gnt = 1'b1;
      tick();                                   // -> WAIT
      imem_gnt = 1'b0;
      check("wr_busy_wait", 32'(fetch_busy), 32'd1);
      redirect_en = 1'b1; redirect_addr = 30'h100;
      tick();                                   // -> FLUSH
      redirect_en = 1'b0;
      check("wr_busy_flush", 32'(fetch_busy), 32'd1);
      check("wr_req_flush",  32'(imem_req),   32'd0);
      tick();
      imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_0000;
      tick();                                   // -> IDLE, dropped
      imem_rvalid = 1'b0;
      check("wr_dropped", 32'(inst_valid), 32'd0);
      tick();                                   // -> REQ
      check("wr_new_req",  32'(imem_req),  32'd1);
      check("wr_new_addr", 32'(imem_addr), 32'h100);
      imem_gnt = 1'b1;
      tick();
      imem_gnt = 1'b0;
      imem_rvalid = 1'b1; imem_rdata = 32'h1234_5678;
      tick();
      imem_rvalid = 1'b0;
      check("wr_first_valid", 32'(inst_valid), 32'd1);
      check("wr_first_pc",    32'(inst_pc),    32'h100);
      check("wr_first_data",  inst_data,       32'h1234_5678);

      // ---- redirect together with rvalid, then redirect in REQ without gnt
      do_reset();
      inst_ready = 1'b1;
      tick();                                   // REQ @0
      imem_gnt = 1'b1;
      tick();                                   // WAIT
      imem_gnt = 1'b0;
      imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_0001;
      redirect_en = 1'b1; redirect_addr = 30'h200;
      tick();                                   // -> IDLE, no push
      imem_rvalid = 1'b0; redirect_en = 1'b0;
      check("rr_no_push", 32'(inst_valid), 32'd0);
      check("rr_req_low", 32'(imem_req),   32'd0);
      tick();                                   // -> REQ
      check("rr_req_addr", 32'(imem_addr), 32'h200);
      check("rr_req_high", 32'(imem_req),  32'd1);
      redirect_en = 1'b1; redirect_addr = 30'h300;
      tick();                                   // REQ -> IDLE
      redirect_en = 1'b0;
      check("rq_req_drop", 32'(imem_req),  32'd0);
      tick();                                   // -> REQ
      check("rq_reissue",      32'(imem_req),  32'd1);
      check("rq_reissue_addr", 32'(imem_addr), 32'h300);

      // ---- PC wrap at 2^30-4
      redirect_en = 1'b1; redirect_addr = 30'h3FFF_FFFC;
      tick();                                   // REQ -> IDLE
      redirect_en = 1'b0;
      tick();                                   // -> REQ
      check("wrap_top_addr", 32'(imem_addr), 32'h3FFF_FFFC);
      imem_gnt = 1'b1;
      tick();                                   // WAIT, fetch_pc wraps
      imem_gnt = 1'b0;
      imem_rvalid = 1'b1; imem_rdata = 32'h0000_0055;
      tick();                                   // push, -> REQ
      imem_rvalid = 1'b0;
      check("wrap_next_addr", 32'(imem_addr), 32'h0);
      check("wrap_next_req",  32'(imem_req),  32'd1);
      check("wrap_head_pc",   32'(inst_pc),   32'h3FFF_FFFC);

      // ---- reset asserted while in WAIT, stale rvalid after release
      imem_gnt = 1'b1;
      tick();                                   // -> WAIT
      imem_gnt = 1'b0;
      check("rw_in_wait", 32'(fetch_busy), 32'd1);
      #2 reset = 1'b0;
      #1;
      check("rw_req",   32'(imem_req),   32'd0);
      check("rw_busy",  32'(fetch_busy), 32'd0);
      check("rw_valid", 32'(inst_valid), 32'd0);
      check("rw_addr",  32'(imem_addr),  32'd0);
      check("rw_pc",    32'(inst_pc),    32'd0);
      tick();
      reset = 1'b1;
      imem_rvalid = 1'b1; imem_rdata = 32'h57A1_E000;
      tick();                                   // IDLE ignores rvalid -> REQ
      imem_rvalid = 1'b0;
      check("rw_stale_ignored", 32'(inst_valid), 32'd0);
      check("rw_first_req",     32'(imem_req),   32'd1);
      check("rw_first_addr",    32'(imem_addr),  32'd0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
